mem_readback: RTL and testbench

Streams the contents of an on-chip block RAM out over a valid/ready interface by driving the RAM's synchronous read port (1-cycle registered read: data for `raddr` appears on `dout` one clock later).
- It is the read-side counterpart to the init/write path, used to dump memory contents after bitstream reinitialisation and compare them against the init file.
- It also produces a running 32-bit sum of every word delivered.
- It sits between the memory's `raddr`/`dout` pins and the host/debug readout logic.

---
 rtl/mem_readback_pkg.sv | 13 +
 rtl/mem_readback_sync_fifo.sv | 57 +++++
 rtl/mem_readback.sv | 140 ++++++++++++++
 tb/tb_mem_readback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readback_pkg.sv
// Shared types and sizing for the memory readback streamer.
package mem_readback_pkg;

    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_readback_sync_fifo.sv
// Small synchronous FIFO with registered storage; head word is visible on o_rdata.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_readback.sv
// Streams a block-RAM region out over valid/ready, driving the RAM's
// registered read port and accumulating a 32-bit checksum of delivered words.
module mem_readback
    import mem_readback_pkg::*;
#(
    parameter  int unsigned WID_MEM   = 32,
    parameter  int unsigned DEPTH_MEM = 2048,
    localparam int unsigned AW        = $clog2(DEPTH_MEM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW:0]        length,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic [WID_MEM-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [31:0]        checksum
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_base;
    logic [AW:0]    r_len;
    logic [AW:0]    r_issue_cnt;
    logic [1:0]     r_inflight;
    logic           r_rd_vld;
    logic           r_rd_last;
    logic [31:0]    r_checksum;

    logic           w_start_ok;
    logic           w_pop;
    logic           w_issue;
    logic           w_issue_last;
    logic           w_last_acc;
    logic [3:0]     w_credit_used;
    logic [AW-1:0]  w_raddr;
    logic [31:0]    w_beat32;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [CW-1:0]  w_fifo_count;
    logic [WID_MEM:0] w_fifo_rdata;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_pop      = out_valid && out_ready;

    // Words buffered or in flight, less the one leaving now, must stay below FIFO depth.
    assign w_credit_used = 4'(w_fifo_count) + 4'(r_inflight) - 4'(w_pop);
    assign w_issue       = (r_state == ST_RUN) && (w_credit_used < 4'(FIFO_DEPTH));
    assign w_issue_last  = w_issue && (r_issue_cnt == r_len - (AW + 1)'(1));

    assign w_raddr   = r_base + r_issue_cnt[AW-1:0];
    assign mem_raddr = 32'(w_raddr);

    assign out_valid  = !w_fifo_empty;
    assign out_data   = w_fifo_rdata[WID_MEM-1:0];
    assign out_last   = out_valid && w_fifo_rdata[WID_MEM];
    assign w_last_acc = w_pop && w_fifo_rdata[WID_MEM];

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign checksum = r_checksum;

    generate
        if (WID_MEM >= 32) begin : g_beat_trunc
            assign w_beat32 = out_data[31:0];
        end else begin : g_beat_ext
            assign w_beat32 = {{(32 - WID_MEM){1'b0}}, out_data};
        end
    endgenerate

    sync_fifo #(
        .WIDTH (WID_MEM + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_rd_vld),
        .i_pop   (w_pop),
        .i_wdata ({r_rd_last, mem_dout}),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    // The tagged last word only leaves once every earlier word has, so its
    // acceptance alone means the FIFO and read pipeline are drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_issue_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_acc) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_inflight  <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_vld   <= w_issue;
            r_rd_last  <= w_issue_last;
            r_inflight <= r_inflight + 2'(w_issue) - 2'(r_rd_vld);
            if (w_start_ok) begin
                r_base      <= base_addr;
                r_len       <= length;
                r_issue_cnt <= '0;
                r_checksum  <= '0;
            end else begin
                if (w_issue) r_issue_cnt <= r_issue_cnt + (AW + 1)'(1);
                if (w_pop)   r_checksum  <= r_checksum + w_beat32;
            end
        end
    end

    a_length_legal: assert property (@(posedge clk) disable iff (reset)
        w_start_ok |-> (length <= (AW + 1)'(DEPTH_MEM)));

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        r_rd_vld |-> (!w_fifo_full || w_pop));

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback: RAM model, expected-beat queue and per-cycle compare.
module tb_mem_readback;

    localparam int unsigned D  = 2048;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [31:0]   mem_raddr;
    logic [31:0]   mem_dout;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [31:0]   checksum;

    always #5 clk = ~clk;

    mem_readback #(
        .WID_MEM   (32),
        .DEPTH_MEM (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_raddr (mem_raddr),
        .mem_dout  (mem_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    logic [31:0] ram [D];
    always @(posedge clk) mem_dout <= ram[mem_raddr[AW-1:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] model_sum;
    logic        mon_en = 1'b0;
    int          mon_cyc, first_lat, last_acc_cyc, n_done, n_acc, cur_len;
    logic        prev_stall, prev_last_acc;
    logic [31:0] prev_data, prev_raddr;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            chk("raddr_upper_zero", mem_raddr[31:AW], 0);
            if (busy && (addr_q.size() == 0 || mem_raddr != prev_raddr)) addr_q.push_back(mem_raddr);
            prev_raddr = mem_raddr;
            chk("checksum_running", checksum, model_sum);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (done) begin
                n_done++;
                chk("done_timing", prev_last_acc || (cur_len == 0 && mon_cyc == 1), 1);
            end
            prev_last_acc = 1'b0;
            if (out_valid) begin
                if (first_lat == 0) first_lat = mon_cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    chk("beat_data", out_data, exp_q[0].data);
                    chk("beat_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        model_sum     = model_sum + exp_q[0].data;
                        prev_last_acc = exp_q[0].last;
                        last_acc_cyc  = mon_cyc;
                        n_acc++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // mode 0: ready held high; mode 1: random ready with a 10-cycle low window.
    task automatic run(input int base, input int len, input int mode, input int abort_at,
                       input bit restart, input logic [31:0] lit_sum);
        beat_t b;
        int    t;
        exp_q.delete();
        addr_q.delete();
        for (int k = 0; k < len; k++) begin
            b.data = ram[AW'((base + k) % D)];
            b.last = (k == len - 1);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        base_addr     = AW'(base + 37);
        length        = 5;
        model_sum     = '0;
        mon_cyc       = 0;
        first_lat     = 0;
        last_acc_cyc  = 0;
        n_done        = 0;
        n_acc         = 0;
        prev_stall    = 1'b0;
        prev_last_acc = 1'b0;
        cur_len       = len;
        mon_en        = 1'b1;
        t = 0;
        while (n_done == 0 && t < 2000) begin
            out_ready = (mode == 0) ? 1'b1 :
                        ((t >= 4 && t < 14) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (restart && t == 4) begin
                start     = 1'b1;
                base_addr = AW'(base + 500);
                length    = 3;
            end else begin
                start = 1'b0;
            end
            if (abort_at > 0 && n_acc >= abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset  = 1'b0;
                mon_en = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                for (int c = 0; c < 3; c++) begin
                    chk("abort_no_done", done, 0);
                    @(posedge clk); #1;
                end
                exp_q.delete();
                out_ready = 1'b1;
                return;
            end
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        chk("done_seen", n_done, 1);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("done_count", n_done, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("checksum_final", checksum, lit_sum);
        chk("model_sum_literal", model_sum, lit_sum);
        if (len > 0) chk("first_latency", first_lat, 3);
        else         chk("no_beats", n_acc, 0);
        if (mode == 0 && len > 0) chk("no_bubbles", last_acc_cyc - first_lat, len - 1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < int'(D); i++) ram[i] = i;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_raddr", mem_raddr, 0);
        reset = 1'b0;

        run(0, 8, 0, 0, 1'b0, 32'd28);

        run(2046, 4, 0, 0, 1'b0, 32'd4094);
        chk("wrap_addr_count", addr_q.size() >= 4, 1);
        if (addr_q.size() >= 4) begin
            chk("wrap_addr0", addr_q[0], 2046);
            chk("wrap_addr1", addr_q[1], 2047);
            chk("wrap_addr2", addr_q[2], 0);
            chk("wrap_addr3", addr_q[3], 1);
        end

        run(5, 0, 0, 0, 1'b0, 32'd0);

        run(0, 16, 1, 0, 1'b0, 32'd120);

        run(0, 16, 1, 5, 1'b0, 32'd0);
        run(0, 16, 0, 0, 1'b0, 32'd120);

        run(100, 8, 0, 0, 1'b1, 32'd828);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
